// File: rtl/vga_sram_scanout.sv
// VGA scan-out engine: raster timing, SRAM word fetch and pixel serialisation,
// with a ring-buffer rolling mode and an IDLE/RUN/FREEZE control FSM.
module vga_sram_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int DATA_W      = 16,
  parameter int PPW         = 2,
  parameter int ADDR_W      = 20,
  parameter int DEPTH_LINES = 480
) (
  input  logic                    pixel_clk,
  input  logic                    R,
  input  logic                    S,
  input  logic                    stop,
  input  logic                    mode,
  input  logic [DATA_W-1:0]       SRAM_DQ,
  output logic [ADDR_W-1:0]       SRAM_ADDR,
  output logic                    SRAM_OE_N,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank_n,
  output logic [DATA_W/PPW-1:0]   pixel,
  output logic                    frame_tick
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WPL      = H_ACTIVE / PPW;
  localparam int PIX_W    = DATA_W / PPW;
  localparam int HC_W     = $clog2(H_TOTAL + 1);
  localparam int VC_W     = $clog2(V_TOTAL + 1);
  localparam int LINE_W   = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int K_W      = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  typedef enum logic [1:0] {IDLE, RUN, FREEZE} state_t;

  state_t              state, state_nxt;
  logic                start_pend, pend_nxt;
  logic                advance;
  logic [HC_W-1:0]     h_cnt, col_word;
  logic [VC_W-1:0]     v_cnt;
  logic [K_W-1:0]      pix_k;
  logic [LINE_W-1:0]   base_line, base_line_nxt, line_idx;
  logic [ADDR_W-1:0]   base_word, base_word_nxt, line_word, cur_line_word;
  logic                h_wrap, h_act, v_act, hs_raw, vs_raw, frame_start, run_nxt;

  logic                s1_hs, s1_vs, s1_blank_n, s1_en;
  logic [K_W-1:0]      s1_k;
  logic [DATA_W-1:0]   dq_reg;
  logic                s2_hs, s2_vs, s2_blank_n, s2_en;
  logic [K_W-1:0]      s2_k;
  logic [PIX_W-1:0]    pix_sel;

  assign h_wrap      = (h_cnt == HC_W'(H_TOTAL - 1));
  assign h_act       = (h_cnt < HC_W'(H_ACTIVE));
  assign v_act       = (v_cnt < VC_W'(V_ACTIVE));
  assign hs_raw      = !((h_cnt >= HC_W'(HS_START)) && (h_cnt < HC_W'(HS_END)));
  assign vs_raw      = !((v_cnt >= VC_W'(VS_START)) && (v_cnt < VC_W'(VS_END)));
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign frame_tick  = frame_start & ~R;

  always_ff @(posedge pixel_clk or posedge R) begin
    if (R) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VC_W'(V_TOTAL - 1)) ? '0 : v_cnt + VC_W'(1);
    end else begin
      h_cnt <= h_cnt + HC_W'(1);
    end
  end

  // Word column and pixel-in-word track h_cnt so no divider is needed.
  always_ff @(posedge pixel_clk or posedge R) begin
    if (R) begin
      pix_k    <= '0;
      col_word <= '0;
    end else if (h_wrap) begin
      pix_k    <= '0;
      col_word <= '0;
    end else if (pix_k == K_W'(PPW - 1)) begin
      pix_k    <= '0;
      col_word <= col_word + HC_W'(1);
    end else begin
      pix_k <= pix_k + K_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = start_pend;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          pend_nxt = 1'b0;
          if (start_pend || S) state_nxt = stop ? FREEZE : RUN;
        end else if (S) begin
          pend_nxt = 1'b1;
        end
      end
      RUN: begin
        pend_nxt = 1'b0;
        if (frame_start) begin
          if (stop)      state_nxt = FREEZE;
          else if (mode) advance   = 1'b1;
        end
      end
      FREEZE: begin
        pend_nxt = 1'b0;
        if (frame_start && !stop) state_nxt = RUN;
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    base_line_nxt = base_line;
    base_word_nxt = base_word;
    if (advance) begin
      if (base_line == LINE_W'(DEPTH_LINES - 1)) begin
        base_line_nxt = '0;
        base_word_nxt = '0;
      end else begin
        base_line_nxt = base_line + LINE_W'(1);
        base_word_nxt = base_word + ADDR_W'(WPL);
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge R) begin
    if (R) begin
      state      <= IDLE;
      start_pend <= 1'b0;
      base_line  <= '0;
      base_word  <= '0;
    end else begin
      state      <= state_nxt;
      start_pend <= pend_nxt;
      base_line  <= base_line_nxt;
      base_word  <= base_word_nxt;
    end
  end

  // Running ring-buffer line pointer; reloaded from the post-tick base so the
  // first line of a frame already reflects that tick's advance.
  always_ff @(posedge pixel_clk or posedge R) begin
    if (R) begin
      line_idx  <= '0;
      line_word <= '0;
    end else if (frame_start) begin
      line_idx  <= base_line_nxt;
      line_word <= base_word_nxt;
    end else if (h_wrap) begin
      if (line_idx == LINE_W'(DEPTH_LINES - 1)) begin
        line_idx  <= '0;
        line_word <= '0;
      end else begin
        line_idx  <= line_idx + LINE_W'(1);
        line_word <= line_word + ADDR_W'(WPL);
      end
    end
  end

  assign cur_line_word = frame_start ? base_word_nxt : line_word;
  assign run_nxt       = (state_nxt != IDLE);

  always_ff @(posedge pixel_clk or posedge R) begin
    if (R) begin
      SRAM_ADDR  <= '0;
      SRAM_OE_N  <= 1'b1;
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
      s1_blank_n <= 1'b0;
      s1_en      <= 1'b0;
      s1_k       <= '0;
    end else begin
      if (h_act && v_act) SRAM_ADDR <= cur_line_word + ADDR_W'(col_word);
      SRAM_OE_N  <= !(run_nxt && v_act);
      s1_hs      <= hs_raw;
      s1_vs      <= vs_raw;
      s1_blank_n <= h_act && v_act;
      s1_en      <= run_nxt && h_act && v_act;
      s1_k       <= pix_k;
    end
  end

  always_ff @(posedge pixel_clk or posedge R) begin
    if (R) begin
      dq_reg     <= '0;
      s2_hs      <= 1'b1;
      s2_vs      <= 1'b1;
      s2_blank_n <= 1'b0;
      s2_en      <= 1'b0;
      s2_k       <= '0;
    end else begin
      dq_reg     <= SRAM_DQ;
      s2_hs      <= s1_hs;
      s2_vs      <= s1_vs;
      s2_blank_n <= s1_blank_n;
      s2_en      <= s1_en;
      s2_k       <= s1_k;
    end
  end

  // LSB-first pixel slice within the fetched word.
  always_comb begin
    pix_sel = '0;
    for (int i = 0; i < PPW; i++) begin
      if (s2_k == K_W'(i)) pix_sel = dq_reg[i*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge pixel_clk or posedge R) begin
    if (R) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      pixel       <= '0;
    end else begin
      vga_hs      <= s2_hs;
      vga_vs      <= s2_vs;
      vga_blank_n <= s2_blank_n;
      pixel       <= s2_en ? pix_sel : '0;
    end
  end

endmodule

// File: tb/tb_vga_sram_scanout.sv
// Directed bench for vga_sram_scanout on a tiny 12x7 raster with a 6-line ring;
// the SRAM model returns its own address as data.
module tb_vga_sram_scanout;

  logic        pixel_clk;
  logic        R, S, stop, mode;
  logic [15:0] SRAM_DQ;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_OE_N, vga_hs, vga_vs, vga_blank_n, frame_tick;
  logic [7:0]  pixel;

  int tests    = 0;
  int failures = 0;
  int cyc      = 0;

  vga_sram_scanout #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .DATA_W(16), .PPW(2), .ADDR_W(20), .DEPTH_LINES(6)
  ) dut (
    .pixel_clk(pixel_clk), .R(R), .S(S), .stop(stop), .mode(mode),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_OE_N(SRAM_OE_N),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .pixel(pixel), .frame_tick(frame_tick)
  );

  assign SRAM_DQ = SRAM_ADDR[15:0];

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic applyStimulus(input logic s_v, input logic stop_v, input logic mode_v);
    S    = s_v;
    stop = stop_v;
    mode = mode_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to a given cycle count after the last reset release, sampling at negedge.
  task automatic goto(input int target);
    while (cyc < target) begin
      @(negedge pixel_clk);
      cyc++;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_hs"},    32'(vga_hs),      32'd1);
    checkOutput({tag, "_vs"},    32'(vga_vs),      32'd1);
    checkOutput({tag, "_blank"}, 32'(vga_blank_n), 32'd0);
    checkOutput({tag, "_pixel"}, 32'(pixel),       32'd0);
    checkOutput({tag, "_addr"},  32'(SRAM_ADDR),   32'd0);
    checkOutput({tag, "_oe_n"},  32'(SRAM_OE_N),   32'd1);
    checkOutput({tag, "_tick"},  32'(frame_tick),  32'd0);
  endtask

  initial begin
    R = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge pixel_clk);
    checkResetOutputs("por");

    // Release: frame tick on cycle 0, idle timing only
    R = 1'b0;
    cyc = 0;
    #1;
    checkOutput("tick_c0", 32'(frame_tick), 32'd1);
    goto(1);   checkOutput("tick_c1", 32'(frame_tick), 32'd0);
    goto(3);   checkOutput("blank_c3", 32'(vga_blank_n), 32'd1);
               checkOutput("idle_pix_c3", 32'(pixel), 32'd0);
               checkOutput("idle_oe_c3", 32'(SRAM_OE_N), 32'd1);
    goto(11);  checkOutput("hs_c11", 32'(vga_hs), 32'd1);
               checkOutput("blank_c11", 32'(vga_blank_n), 32'd0);
    goto(12);  checkOutput("hs_c12", 32'(vga_hs), 32'd0);
    goto(13);  checkOutput("hs_c13", 32'(vga_hs), 32'd0);
    goto(14);  checkOutput("hs_c14", 32'(vga_hs), 32'd1);
    goto(62);  checkOutput("vs_c62", 32'(vga_vs), 32'd1);
    goto(63);  checkOutput("vs_c63", 32'(vga_vs), 32'd0);
    goto(74);  checkOutput("vs_c74", 32'(vga_vs), 32'd0);
    goto(75);  checkOutput("vs_c75", 32'(vga_vs), 32'd1);
    goto(83);  checkOutput("tick_c83", 32'(frame_tick), 32'd0);
    goto(84);  checkOutput("tick_c84", 32'(frame_tick), 32'd1);

    // Static start: S pulse mid-frame 1, RUN from frame 2
    goto(100); applyStimulus(1'b1, 1'b0, 1'b0);
    goto(101); applyStimulus(1'b0, 1'b0, 1'b0);
    goto(168); checkOutput("tick_c168", 32'(frame_tick), 32'd1);
    goto(171); checkOutput("f2l0_p0", 32'(pixel), 32'd0);
               checkOutput("f2_oe", 32'(SRAM_OE_N), 32'd0);
    goto(172); checkOutput("f2l0_p1", 32'(pixel), 32'd0);
               checkOutput("f2l0_addr", 32'(SRAM_ADDR), 32'd1);
    goto(173); checkOutput("f2l0_p2", 32'(pixel), 32'd1);
    goto(174); checkOutput("f2l0_p3", 32'(pixel), 32'd0);
    goto(175); checkOutput("f2l0_p4", 32'(pixel), 32'd2);
    goto(177); checkOutput("f2l0_p6", 32'(pixel), 32'd3);
    goto(178); checkOutput("f2l0_p7", 32'(pixel), 32'd0);
    goto(207); checkOutput("f2l3_p0", 32'(pixel), 32'd12);
    goto(209); checkOutput("f2l3_p2", 32'(pixel), 32'd13);
    goto(214); checkOutput("f2l3_p7", 32'(pixel), 32'd0);
    goto(215); checkOutput("hblank_pix", 32'(pixel), 32'd0);
               checkOutput("hblank_addr_held", 32'(SRAM_ADDR), 32'd15);
    goto(217); checkOutput("vblank_oe", 32'(SRAM_OE_N), 32'd1);
    goto(257); checkOutput("f3l0_p2", 32'(pixel), 32'd1);

    // Rolling mode: base advances one line per frame, wrapping at 6
    goto(260); applyStimulus(1'b0, 1'b0, 1'b1);
    goto(339); checkOutput("f4_first", 32'(pixel), 32'd4);
    goto(341); checkOutput("f4_p2", 32'(pixel), 32'd5);
    goto(423); checkOutput("f5_first", 32'(pixel), 32'd8);
    goto(507); checkOutput("f6_first", 32'(pixel), 32'd12);
    goto(591); checkOutput("f7_first", 32'(pixel), 32'd16);
    goto(627); checkOutput("f7l3_p0", 32'(pixel), 32'd4);
    goto(629); checkOutput("f7l3_p2", 32'(pixel), 32'd5);
    goto(675); checkOutput("f8_first", 32'(pixel), 32'd20);
    goto(689); checkOutput("f8l1_wrap", 32'(pixel), 32'd1);
    goto(761); checkOutput("f9_p2", 32'(pixel), 32'd1);
    goto(763); checkOutput("f9_p4", 32'(pixel), 32'd2);

    // Freeze: base held while stop is high, plus one frame after release
    goto(780);  applyStimulus(1'b0, 1'b1, 1'b1);
    goto(843);  checkOutput("f10_first", 32'(pixel), 32'd0);
    goto(845);  checkOutput("f10_p2", 32'(pixel), 32'd1);
    goto(929);  checkOutput("f11_p2", 32'(pixel), 32'd1);
    goto(950);  applyStimulus(1'b0, 1'b0, 1'b1);
    goto(1013); checkOutput("f12_p2", 32'(pixel), 32'd1);
    goto(1095); checkOutput("f13_first", 32'(pixel), 32'd4);
    goto(1097); checkOutput("f13_p2", 32'(pixel), 32'd5);
                checkOutput("f13_addr", 32'(SRAM_ADDR), 32'd6);
                checkOutput("f13_oe", 32'(SRAM_OE_N), 32'd0);

    // Mid-line reset takes effect immediately
    R = 1'b1;
    #1;
    checkResetOutputs("midline");
    repeat (2) @(negedge pixel_clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    R = 1'b0;
    cyc = 0;

    // Simultaneous S and stop in IDLE go straight to FREEZE
    goto(5);   checkOutput("idle2_pix", 32'(pixel), 32'd0);
               checkOutput("idle2_blank", 32'(vga_blank_n), 32'd1);
    goto(10);  applyStimulus(1'b1, 1'b1, 1'b1);
    goto(11);  applyStimulus(1'b0, 1'b1, 1'b1);
    goto(84);  checkOutput("frz_tick", 32'(frame_tick), 32'd1);
    goto(89);  checkOutput("frz_f1_p2", 32'(pixel), 32'd1);
    goto(172); checkOutput("frz_oe", 32'(SRAM_OE_N), 32'd0);
    goto(173); checkOutput("frz_f2_p2", 32'(pixel), 32'd1);

    // Reset during FREEZE returns to IDLE
    R = 1'b1;
    #1;
    checkOutput("frz_rst_pix", 32'(pixel), 32'd0);
    checkOutput("frz_rst_oe", 32'(SRAM_OE_N), 32'd1);
    checkOutput("frz_rst_blank", 32'(vga_blank_n), 32'd0);
    repeat (2) @(negedge pixel_clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    R = 1'b0;
    cyc = 0;
    goto(89);  checkOutput("post_rst_idle_pix", 32'(pixel), 32'd0);
               checkOutput("post_rst_idle_oe", 32'(SRAM_OE_N), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/vga_sram_scanout.md
Name: vga_sram_scanout

Overview:
- Parametrised VGA scan-out engine: generates VGA timing on pixel_clk, fetches frame words from external async SRAM (DE2-115 16-bit bus) and serialises them into pixels.
- Successor to the fixed 640x480 VGA/SRAM/control block. Generalised in timing, data width and pixels-per-word.
- Adds a ring-buffer "rolling" (waterfall) display mode for streamed UART data, plus an IDLE/RUN/FREEZE control FSM.
- Sits between the UART-to-SRAM writer and the board VGA DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_BP, 33, vertical back porch (lines).
- DATA_W, 16, SRAM data width.
- PPW, 2, pixels per SRAM word; must divide DATA_W and H_ACTIVE.
- ADDR_W, 20, SRAM address width.
- DEPTH_LINES, 480, lines in the SRAM ring buffer; must be >= V_ACTIVE.

Ports:
- pixel_clk, in, 1, sole clock.
- R, in, 1, asynchronous active-high reset.
- S, in, 1, start pulse (level-sampled).
- stop, in, 1, freeze request (level).
- mode, in, 1, 0 = static frame, 1 = rolling.
- SRAM_DQ, in, DATA_W, SRAM read data.
- SRAM_ADDR, out, ADDR_W, word address.
- SRAM_OE_N, out, 1, output enable, active low.
- vga_hs, out, 1, hsync, active low.
- vga_vs, out, 1, vsync, active low.
- vga_blank_n, out, 1, high during active video.
- pixel, out, DATA_W/PPW, pixel value.
- frame_tick, out, 1, one-cycle pulse at h_cnt=0, v_cnt=0.

Behaviour:

Reset and timing
- One clock; reset is asynchronous and active-high (R). Clock port is pixel_clk.
- While R=1: vga_hs=1, vga_vs=1, vga_blank_n=0, pixel=0, SRAM_ADDR=0, SRAM_OE_N=1, frame_tick=0, counters=0, base_line=0, state=IDLE. Reset mid-frame aborts the frame immediately.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h_cnt wraps at H_TOTAL-1; v_cnt increments on h_cnt wrap and wraps at V_TOTAL-1.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync low for the analogous v_cnt range.

Pipeline
- 3 stages: stage 1 registers SRAM_ADDR; stage 2 registers SRAM_DQ; stage 3 selects the pixel.
- vga_hs, vga_vs, vga_blank_n and pixel all lag the counter state by exactly 3 cycles, so they stay mutually aligned.
- frame_tick is not delayed.

Addressing
- WPL=H_ACTIVE/PPW words per line.
- line_idx=(base_line+v_cnt) mod DEPTH_LINES, computed via a wrapping running register, not a multiplier.
- SRAM_ADDR = line_idx*WPL + h_cnt/PPW. Held during blanking.
- Pixel k within a word (k = h_cnt mod PPW) = bits [k*DATA_W/PPW +: DATA_W/PPW], LSB-first.
- pixel=0 whenever the delayed blank_n=0 or state=IDLE.

FSM (transitions evaluated only on the cycle frame_tick=1, except reset)
- IDLE: timing runs, SRAM_OE_N=1, pixel=0.
  - S was seen since the last frame_tick and stop=1 -> FREEZE.
  - S was seen and stop=0 -> RUN.
  - S is latched into a sticky pending flag until the next frame_tick.
- RUN: SRAM_OE_N=0 during active lines.
  - If mode=1, base_line <= (base_line+1) mod DEPTH_LINES at each frame_tick.
  - stop=1 at frame_tick -> FREEZE; base_line is not advanced on that tick.
- FREEZE: reads continue; base_line held.
  - stop=0 at frame_tick -> RUN; the advance resumes at the following frame_tick.
- S is ignored in RUN and FREEZE. mode changes take effect at frame_tick.

Test Plan:
Common setup: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=12); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); PPW=2; DEPTH_LINES=6; WPL=4. SRAM model returns DQ=address.

1. Reset: assert R mid-line -> same cycle hs=vs=1, blank_n=0, pixel=0, SRAM_ADDR=0, SRAM_OE_N=1. Release -> frame_tick at cycle 0, then every 84 cycles.
2. Timing: no S -> vga_hs low 2 of every 12 cycles, starting 3 cycles after h_cnt=9. vga_vs low 12 cycles per 84. pixel stays 0, SRAM_OE_N stays 1.
3. Start, mode=0: S pulse mid-frame -> first active line of the next frame gives pixel sequence 0,0,1,0,2,0,3,0 (words 0..3); line 3 gives words 12..15; identical every frame.
4. Rolling: mode=1 -> first word of successive frames is 4, 8, 12, 16, 20, 0 (wrap). With base_line=4, line 3 reads words 4..7, since (4+3) mod 6 = 1.
5. Freeze: stop raised in RUN, mode=1 -> base_line held from the next frame_tick and the same addresses repeat each frame. Drop stop -> one more frame unchanged, then the increment resumes.
6. Simultaneous S=1 and stop=1 in IDLE -> FREEZE at the next frame_tick; pixels enabled, base_line stays 0. R asserted during FREEZE -> IDLE immediately.
